pwm_button_conditioner: RTL and testbench
=========================================

# pwm_button_conditioner

Input-conditioning stage directly upstream of the PWM signal generator. Takes the two raw push-button levels (duty up / duty down), synchronises and debounces them, and emits the single-cycle `xu` / `xd` step pulses that the generator consumes. An optional auto-repeat produces a steady pulse train while a button is held, for fast duty sweeps.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 4: consecutive cycles a synchronised level must differ from the stable level before the stable level flips; ≥1
- `REPEAT_DELAY`, 20: cycles from the press pulse to the first repeat pulse; ≥2
- `REPEAT_RATE`, 8: cycles between subsequent repeat pulses; ≥2

Ports:
- `clk`  in  1  single clock domain
- `rst`  in  1  reset, asynchronous, active-high
- `ena`  in  1  pulse enable; debouncing runs regardless
- `btn_up`  in  1  raw up-button level, asynchronous
- `btn_dn`  in  1  raw down-button level, asynchronous
- `xu`  out  1  registered one-cycle "step up" pulse to the generator
- `xd`  out  1  registered one-cycle "step down" pulse to the generator

## Operation
- Per button: 2-flop synchroniser (`s1`, `s2`) → debounce counter `cnt` (width `$clog2(DEBOUNCE_CYCLES+1)`) → `stable` level → `stable_d` (previous stable).
- Debounce: if `s2 == stable`, `cnt` clears to 0; else `cnt` increments. On the edge where `cnt` would reach `DEBOUNCE_CYCLES`, `stable` toggles and `cnt` clears. Glitches shorter than `DEBOUNCE_CYCLES` cycles never reach `stable`.
- Press event: `stable & ~stable_d`. Release produces no pulse.
- Exclusivity: a pulse is issued for a button only while its `stable`=1 and the other button's `stable`=0. A press edge arriving while the other button is stably held is discarded and not replayed on release of the other.
- `ena`=0: `xu`/`xd` forced 0; press edges during this time are lost; repeat timers cleared.
- `xu` and `xd` are never high in the same cycle.
- Reset: all synchroniser, stable, counter, timer and output flops clear to 0; `xu`=`xd`=0 asynchronously. A button held through reset release is seen as a fresh press.

## Timing
- Raw level change first sampled at edge k: `s2` updates at k+1, `stable` at k+1+`DEBOUNCE_CYCLES`, `xu`/`xd` high from edge k+2+`DEBOUNCE_CYCLES` for exactly one cycle.
- Release takes the same `DEBOUNCE_CYCLES`+1 edges to clear `stable`.
- Repeat timer (width `$clog2(max(REPEAT_DELAY,REPEAT_RATE)+1)`) loads 0 on the press-pulse cycle, increments while the button is sole-held and `ena`=1; otherwise held at 0 and repeat phase reset to "delay".
- Delay phase: when timer reaches `REPEAT_DELAY`, issue pulse, enter rate phase, timer=0. Rate phase: pulse each time timer reaches `REPEAT_RATE`, timer=0.
- After the other button is released, a still-held button restarts in delay phase (first repeat `REPEAT_DELAY` cycles later); no press pulse.
- Pulse register output = press pulse OR repeat pulse, gated by exclusivity and `ena`.

## Configuration
- `PWM_BTN_AUTOREPEAT_EN` defined: repeat timer and phase logic built as above.
- Not defined: repeat logic absent; exactly one pulse per debounced press regardless of hold length.

## Test plan
Defaults (`DEBOUNCE_CYCLES`=4, `REPEAT_DELAY`=20, `REPEAT_RATE`=8), `ena`=1, `btn_up` rises before edge 0:
- Clean press, released at edge 10 → `xu` high only after edge 6, one cycle; `xd` stays 0; no pulse on release.
- Glitch: `btn_up` high for edges 0–2 then low → `xu` never asserts; `stable` stays 0.
- Hold 60 cycles with `PWM_BTN_AUTOREPEAT_EN` → `xu` pulses after edges 6, 26, 34, 42, 50, 58 (6 pulses); without macro → single pulse at 6.
- `btn_dn` held stable, then `btn_up` pressed, `btn_dn` released 30 cycles later → no `xu` at press; with auto-repeat, first `xu` `REPEAT_DELAY` cycles after `btn_dn` stable falls; `xd` 0 throughout overlap.
- `ena`=0 during press → no pulse; `ena`→1 while held → no press pulse, repeat (if enabled) starts 20 cycles later.
- `rst` pulsed at edge 30 during hold → `xu`=0 immediately; after release with `btn_up` still high, new `xu` 6 edges after first post-reset sampling edge.

Source files
------------

// File: rtl/pwm_button_conditioner.sv
// pwm_button_conditioner
// Conditions the raw duty-up / duty-down push buttons for the PWM generator.
// Each button is synchronised, debounced and edge-detected into single-cycle
// xu / xd step pulses. A pulse only goes out while its button is the sole
// button held.
// Optional feature: define PWM_BTN_AUTOREPEAT_EN to build the auto-repeat
// timer, which emits a steady pulse train while a button stays held.
// Without it, each debounced press gives exactly one pulse.

module pwm_button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    input  logic btn_up,
    input  logic btn_dn,
    output logic xu,
    output logic xd
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Index 0 is the up button, index 1 is the down button.
    logic [1:0] raw;
    logic [1:0] s1;
    logic [1:0] s2;
    logic [1:0] stable;
    logic [1:0] stable_d;
    logic [1:0][CNT_W-1:0] cnt;
    logic [1:0] press;
    logic [1:0] sole;
    logic [1:0] rep_hit;
    logic [1:0] pulse;

    assign raw = {btn_dn, btn_up};

    // Two-flop synchroniser for the asynchronous button levels
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // Debounce: stable flips only after DEBOUNCE_CYCLES consecutive disagreeing samples
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable <= '0;
            cnt    <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_LAST) begin
                    stable[i] <= ~stable[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Previous stable level, used to find the rising (press) edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stable_d <= '0;
        end else begin
            stable_d <= stable;
        end
    end

    assign press = stable & ~stable_d;
    assign sole  = stable & ~{stable[0], stable[1]};

`ifdef PWM_BTN_AUTOREPEAT_EN

    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int TMR_W   = $clog2(REP_MAX + 1);
    localparam logic [TMR_W-1:0] DELAY_LAST = TMR_W'(REPEAT_DELAY - 1);
    localparam logic [TMR_W-1:0] RATE_LAST  = TMR_W'(REPEAT_RATE - 1);

    typedef enum logic {
        PH_DELAY = 1'b0,
        PH_RATE  = 1'b1
    } phase_t;

    phase_t phase     [2];
    phase_t phase_nxt [2];
    logic [1:0][TMR_W-1:0] tmr;
    logic [1:0][TMR_W-1:0] tmr_nxt;

    // Repeat phase and timer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmr      <= '0;
            phase[0] <= PH_DELAY;
            phase[1] <= PH_DELAY;
        end else begin
            tmr      <= tmr_nxt;
            phase[0] <= phase_nxt[0];
            phase[1] <= phase_nxt[1];
        end
    end

    // Repeat next-state: count while sole-held and enabled, fire on the
    // cycle the timer would reach the delay (first repeat) or the rate
    always_comb begin
        tmr_nxt      = tmr;
        phase_nxt[0] = phase[0];
        phase_nxt[1] = phase[1];
        rep_hit      = '0;
        for (int i = 0; i < 2; i++) begin
            if (!ena || !sole[i]) begin
                tmr_nxt[i]   = '0;
                phase_nxt[i] = PH_DELAY;
            end else if (press[i]) begin
                tmr_nxt[i]   = '0;
                phase_nxt[i] = PH_DELAY;
            end else if ((phase[i] == PH_DELAY && tmr[i] == DELAY_LAST) ||
                         (phase[i] == PH_RATE  && tmr[i] == RATE_LAST)) begin
                rep_hit[i]   = 1'b1;
                tmr_nxt[i]   = '0;
                phase_nxt[i] = PH_RATE;
            end else begin
                tmr_nxt[i] = tmr[i] + 1'b1;
            end
        end
    end

`else

    assign rep_hit = '0;

`endif

    // Sole-held gating makes the two pulses mutually exclusive
    assign pulse = {2{ena}} & sole & (press | rep_hit);

    // Registered step pulses to the generator
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            xu <= 1'b0;
            xd <= 1'b0;
        end else begin
            xu <= pulse[0];
            xd <= pulse[1];
        end
    end

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// tb_pwm_button_conditioner
// Self-checking bench for pwm_button_conditioner with default parameters.
// Expectations follow PWM_BTN_AUTOREPEAT_EN when it is defined for the build.

module tb_pwm_button_conditioner;

    localparam int DC = 4;
    localparam int RD = 20;
    localparam int RR = 8;
`ifdef PWM_BTN_AUTOREPEAT_EN
    localparam bit AUTOREP = 1'b1;
`else
    localparam bit AUTOREP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ena;
    logic btn_up;
    logic btn_dn;
    logic xu;
    logic xd;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic up;
        logic dn;
        logic en;
        logic exp_xu;
        logic exp_xd;
    } vec_t;

    vec_t table_v [32];

    // Reference model state: edges are counted from the first edge after reset
    bit raw_hist [2][8192];
    int ne;
    bit m_stable [2];
    bit m_rose   [2];
    int last_flip[2];
    int anchor   [2];
    bit first    [2];
    bit m_xu;
    bit m_xd;

    always #5 clk = ~clk;

    pwm_button_conditioner #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY(RD),
        .REPEAT_RATE(RR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ena(ena),
        .btn_up(btn_up),
        .btn_dn(btn_dn),
        .xu(xu),
        .xd(xd)
    );

    task automatic model_reset();
        ne = 0;
        m_xu = 1'b0;
        m_xd = 1'b0;
        for (int i = 0; i < 2; i++) begin
            m_stable[i]  = 1'b0;
            m_rose[i]    = 1'b0;
            last_flip[i] = -1;
            anchor[i]    = 0;
            first[i]     = 1'b1;
        end
    endtask

    // Behaviour at one clock edge, from the levels present just before it.
    // Debounced level flips once the synchronised level (raw two edges
    // earlier) has disagreed with it for DC edges since the last flip.
    // Repeats fire a fixed number of edges after the last press, repeat or
    // moment the button stopped being the sole enabled one.
    task automatic model_edge(input bit up, input bit dn, input bit en);
        bit raw [2];
        bit st_old [2];
        bit sole [2];
        bit pulse [2];
        raw[0] = up;
        raw[1] = dn;
        st_old = m_stable;
        sole[0] = st_old[0] && !st_old[1];
        sole[1] = st_old[1] && !st_old[0];
        for (int i = 0; i < 2; i++) begin
            bit hit;
            bit all_diff;
            hit = 1'b0;
            if (en && sole[i]) begin
                if (m_rose[i]) begin
                    anchor[i] = ne;
                    first[i]  = 1'b1;
                end else if (AUTOREP && (ne - anchor[i]) == (first[i] ? RD : RR)) begin
                    hit       = 1'b1;
                    anchor[i] = ne;
                    first[i]  = 1'b0;
                end
            end else begin
                anchor[i] = ne;
                first[i]  = 1'b1;
            end
            pulse[i] = en && sole[i] && (m_rose[i] || hit);

            all_diff = (ne - last_flip[i]) >= DC;
            if (all_diff) begin
                for (int j = 0; j < DC; j++) begin
                    int e;
                    bit s2v;
                    e = ne - j;
                    s2v = (e >= 2) ? raw_hist[i][e-2] : 1'b0;
                    if (s2v == st_old[i]) all_diff = 1'b0;
                end
            end
            m_rose[i] = all_diff && !st_old[i];
            if (all_diff) begin
                m_stable[i]  = !st_old[i];
                last_flip[i] = ne;
            end
            raw_hist[i][ne] = raw[i];
        end
        m_xu = pulse[0];
        m_xd = pulse[1];
        ne++;
    endtask

    task automatic applyStimulus(input logic up, input logic dn, input logic en);
        btn_up = up;
        btn_dn = dn;
        ena    = en;
        @(posedge clk);
        model_edge(up, dn, en);
        #1;
    endtask

    task automatic checkOutput(input logic exp_xu, input logic exp_xd,
                               input string tag, input int idx);
        vectors++;
        if (xu !== exp_xu || xd !== exp_xd) begin
            miscompares++;
            $display("[TB] FAIL %s[%0d]: got xu=%b xd=%b, expected xu=%b xd=%b",
                     tag, idx, xu, xd, exp_xu, exp_xd);
        end
    endtask

    initial begin
        logic ex;
        logic cur_up;
        logic cur_dn;
        logic cur_en;

        // Reset state
        rst = 1'b1;
        ena = 1'b1;
        btn_up = 1'b0;
        btn_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput(1'b0, 1'b0, "reset", i);
        end
        rst = 1'b0;
        model_reset();

        // Table: clean press released at edge 10, then a 3-edge glitch
        for (int i = 0; i < 32; i++) begin
            table_v[i].up     = (i < 10) || (i >= 20 && i < 23);
            table_v[i].dn     = 1'b0;
            table_v[i].en     = 1'b1;
            table_v[i].exp_xu = (i == 6);
            table_v[i].exp_xd = 1'b0;
        end
        for (int i = 0; i < 32; i++) begin
            applyStimulus(table_v[i].up, table_v[i].dn, table_v[i].en);
            checkOutput(table_v[i].exp_xu, table_v[i].exp_xd, "table", i);
        end

        // Hold up for 60 edges, then idle
        for (int k = 0; k < 70; k++) begin
            applyStimulus(k < 60, 1'b0, 1'b1);
            ex = (k == 6) || (AUTOREP && (k == 26 || k == 34 || k == 42 || k == 50 || k == 58));
            checkOutput(ex, 1'b0, "hold60", k);
        end

        // Down held, up pressed at 8, down released at 38, up released at 88
        for (int k = 0; k < 100; k++) begin
            applyStimulus(k >= 8 && k < 88, k < 38, 1'b1);
            ex = AUTOREP && (k == 63 || k == 71 || k == 79 || k == 87);
            checkOutput(ex, k == 6, "overlap", k);
        end

        // Press while disabled, enable at edge 10, release at 39
        for (int k = 0; k < 50; k++) begin
            applyStimulus(k < 39, 1'b0, k >= 10);
            ex = AUTOREP && (k == 29 || k == 37);
            checkOutput(ex, 1'b0, "ena_gate", k);
        end

        // Reset during a hold clears the pulse at once, then a fresh press
        for (int k = 0; k < 7; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b1);
            checkOutput(k == 6, 1'b0, "pre_rst", k);
        end
        rst = 1'b1;
        #1;
        checkOutput(1'b0, 1'b0, "async_rst", 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(k < 8, 1'b0, 1'b1);
            checkOutput(k == 6, 1'b0, "post_rst", k);
        end

        // Randomised levels checked against the reference model
        cur_up = 1'b0;
        cur_dn = 1'b0;
        cur_en = 1'b1;
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 24) == 0) cur_up = ~cur_up;
            if ($urandom_range(0, 24) == 0) cur_dn = ~cur_dn;
            if ($urandom_range(0, 59) == 0) cur_en = ~cur_en;
            applyStimulus(cur_up, cur_dn, cur_en);
            checkOutput(m_xu, m_xd, "random", k);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
